// File: rtl/qracc_stream_checker.sv
// qracc_stream_checker
//   Multi-channel scoreboard for qr_acc_top output streams. Every channel has
//   its own expected-word FIFO. Each accepted DUT beat pops the FIFO head and
//   compares it with the DUT word under a mask. The block counts mismatches,
//   captures the first failure and runs a stall watchdog. The result is a
//   single pass/fail/timeout verdict.
//
// Ports
//   clk, nrst                     clock, asynchronous active-low reset
//   start_i                       flush FIFOs, clear results, (re)enter RUN
//   num_items_i, mask_i           beats per channel / compare mask, sampled on start_i
//   exp_valid_i/exp_data_i        expected-word push, per channel
//   exp_ready_o                   expected FIFO can accept, per channel
//   dut_valid_i/dut_data_i        DUT output beats, per channel
//   dut_ready_o                   checker accepts DUT beat, per channel
//   busy_o, done_o, pass_o, timeout_o   status / verdict
//   err_cnt_o                     saturating mismatch count
//   first_err_*                   channel, beat index, expected and got word of first mismatch
module qracc_stream_checker #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned EXP_DEPTH   = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         num_items_i,
  input  logic [DATA_W-1:0]        mask_i,
  input  logic [NUM_CH-1:0]        exp_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] exp_data_i,
  output logic [NUM_CH-1:0]        exp_ready_o,
  input  logic [NUM_CH-1:0]        dut_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] dut_data_i,
  output logic [NUM_CH-1:0]        dut_ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         err_cnt_o,
  output logic [CH_W-1:0]          first_err_ch_o,
  output logic [CNT_W-1:0]         first_err_idx_o,
  output logic [DATA_W-1:0]        first_err_exp_o,
  output logic [DATA_W-1:0]        first_err_got_o
);

  localparam int unsigned PTR_W = $clog2(EXP_DEPTH);
  localparam int unsigned FCW   = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] mask_q;

  logic [DATA_W-1:0] mem      [NUM_CH][EXP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [FCW-1:0]    fcnt_q   [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt_nxt [NUM_CH];
  logic [DATA_W-1:0] head     [NUM_CH];

  logic [NUM_CH-1:0] push, beat, mismatch;
  logic              run, all_done, any_beat;

  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W:0]    mis_cnt, err_sum;

  logic              fe_valid_q;
  logic              fe_hit;
  logic [CH_W-1:0]   fe_ch;
  logic [CNT_W-1:0]  fe_idx;
  logic [DATA_W-1:0] fe_exp, fe_got;

  logic [WD_W-1:0]   wdog_q, wdog_nxt;

  assign run = (state_q == S_RUN);

  // Per-channel handshakes. Ready depends only on registered state, so a
  // push into a full FIFO is refused even when a pop happens that cycle.
  always_comb begin
    all_done = 1'b1;
    any_beat = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      head[c]        = mem[c][rd_ptr_q[c]];
      exp_ready_o[c] = run && (fcnt_q[c] != FCW'(EXP_DEPTH));
      dut_ready_o[c] = run && (fcnt_q[c] != '0) && (ch_cnt_q[c] < num_q);
      push[c]        = exp_valid_i[c] && exp_ready_o[c];
      beat[c]        = dut_valid_i[c] && dut_ready_o[c];
      mismatch[c]    = beat[c] &&
                       ((dut_data_i[c*DATA_W +: DATA_W] & mask_q) != (head[c] & mask_q));
      ch_cnt_nxt[c]  = ch_cnt_q[c] + CNT_W'(beat[c]);
      if (ch_cnt_nxt[c] != num_q) all_done = 1'b0;
      if (beat[c]) any_beat = 1'b1;
    end
  end

  // Mismatch popcount, saturating accumulate, lowest-channel first error.
  always_comb begin
    mis_cnt = '0;
    fe_hit  = 1'b0;
    fe_ch   = '0;
    fe_idx  = '0;
    fe_exp  = '0;
    fe_got  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      mis_cnt = mis_cnt + (CNT_W+1)'(mismatch[c]);
      if (mismatch[c] && !fe_hit) begin
        fe_hit = 1'b1;
        fe_ch  = CH_W'(c);
        fe_idx = ch_cnt_q[c];
        fe_exp = head[c];
        fe_got = dut_data_i[c*DATA_W +: DATA_W];
      end
    end
    err_sum = {1'b0, err_q} + mis_cnt;
    err_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  // Completion uses post-beat counts so done_o follows the last beat by one cycle.
  always_comb begin
    wdog_nxt = any_beat ? '0 : wdog_q + WD_W'(1);
    state_d  = state_q;
    case (state_q)
      S_RUN: begin
        if (all_done)                            state_d = S_DONE;
        else if (wdog_nxt == WD_W'(TIMEOUT_CYC)) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
    if (start_i) state_d = S_RUN;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr_q[c]] <= exp_data_i[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      num_q      <= '0;
      mask_q     <= '0;
      err_q      <= '0;
      wdog_q     <= '0;
      fe_valid_q <= 1'b0;
      first_err_ch_o  <= '0;
      first_err_idx_o <= '0;
      first_err_exp_o <= '0;
      first_err_got_o <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        fcnt_q[c]   <= '0;
        ch_cnt_q[c] <= '0;
      end
    end else if (start_i) begin
      num_q      <= num_items_i;
      mask_q     <= mask_i;
      err_q      <= '0;
      wdog_q     <= '0;
      fe_valid_q <= 1'b0;
      first_err_ch_o  <= '0;
      first_err_idx_o <= '0;
      first_err_exp_o <= '0;
      first_err_got_o <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        fcnt_q[c]   <= '0;
        ch_cnt_q[c] <= '0;
      end
    end else if (run) begin
      err_q  <= err_d;
      wdog_q <= wdog_nxt;
      if (fe_hit && !fe_valid_q) begin
        fe_valid_q      <= 1'b1;
        first_err_ch_o  <= fe_ch;
        first_err_idx_o <= fe_idx;
        first_err_exp_o <= fe_exp;
        first_err_got_o <= fe_got;
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        ch_cnt_q[c] <= ch_cnt_nxt[c];
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        if (beat[c]) rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        case ({push[c], beat[c]})
          2'b10:   fcnt_q[c] <= fcnt_q[c] + FCW'(1);
          2'b01:   fcnt_q[c] <= fcnt_q[c] - FCW'(1);
          default: fcnt_q[c] <= fcnt_q[c];
        endcase
      end
    end
  end

  assign busy_o    = run;
  assign done_o    = (state_q == S_DONE) || (state_q == S_TIMEOUT);
  assign timeout_o = (state_q == S_TIMEOUT);
  assign pass_o    = done_o && (err_q == '0) && !timeout_o;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_qracc_stream_checker.sv
// Directed bench for qracc_stream_checker (default parameters: 4 channels,
// 8-bit words, 16-deep FIFOs, 1024-cycle watchdog).
module tb_qracc_stream_checker;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start_i;
  logic [15:0] num_items_i;
  logic [7:0]  mask_i;
  logic [3:0]  exp_valid_i;
  logic [31:0] exp_data_i;
  logic [3:0]  exp_ready_o;
  logic [3:0]  dut_valid_i;
  logic [31:0] dut_data_i;
  logic [3:0]  dut_ready_o;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_cnt_o;
  logic [1:0]  first_err_ch_o;
  logic [15:0] first_err_idx_o;
  logic [7:0]  first_err_exp_o, first_err_got_o;

  qracc_stream_checker #(
    .NUM_CH(4), .DATA_W(8), .EXP_DEPTH(16), .CNT_W(16), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .num_items_i(num_items_i),
    .mask_i(mask_i), .exp_valid_i(exp_valid_i), .exp_data_i(exp_data_i),
    .exp_ready_o(exp_ready_o), .dut_valid_i(dut_valid_i), .dut_data_i(dut_data_i),
    .dut_ready_o(dut_ready_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .first_err_ch_o(first_err_ch_o),
    .first_err_idx_o(first_err_idx_o), .first_err_exp_o(first_err_exp_o),
    .first_err_got_o(first_err_got_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_w [4][32];
  logic [7:0] got_w [4][32];
  int e_idx [4];
  int d_idx [4];
  logic last_neg_done;
  bit ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 32; i++) begin
        exp_w[c][i] = 8'(c * 40 + i * 7 + 3);
        got_w[c][i] = exp_w[c][i];
      end
  endtask

  task automatic do_start(input int num, input logic [7:0] mask);
    start_i     = 1'b1;
    num_items_i = 16'(num);
    mask_i      = mask;
    exp_valid_i = '0;
    dut_valid_i = '0;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e_idx[c] = 0;
      d_idx[c] = 0;
    end
  endtask

  // Pushes elen expected words and dlen DUT beats per channel; returns when
  // all are transferred (ok=1) or the cycle budget runs out (ok=0).
  task automatic drive(input int elen, input int dlen, input bit dut_en, input bit rnd,
                       input int budget, output bit done_ok);
    logic [3:0] ef, df;
    bit fin;
    done_ok = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      fin = 1'b1;
      for (int c = 0; c < 4; c++)
        if (e_idx[c] < elen || d_idx[c] < dlen) fin = 1'b0;
      if (fin) begin
        done_ok = 1'b1;
        break;
      end
      for (int c = 0; c < 4; c++) begin
        exp_valid_i[c] = (e_idx[c] < elen) && (!rnd || $urandom_range(0, 1) == 1);
        dut_valid_i[c] = dut_en && (d_idx[c] < dlen) && (!rnd || $urandom_range(0, 1) == 1);
        exp_data_i[c*8 +: 8] = exp_w[c][e_idx[c] % 32];
        dut_data_i[c*8 +: 8] = got_w[c][d_idx[c] % 32];
      end
      @(negedge clk);
      ef = exp_valid_i & exp_ready_o;
      df = dut_valid_i & dut_ready_o;
      last_neg_done = done_o;
      tick();
      for (int c = 0; c < 4; c++) begin
        if (ef[c]) e_idx[c]++;
        if (df[c]) d_idx[c]++;
      end
    end
    exp_valid_i = '0;
    dut_valid_i = '0;
  endtask

  initial begin
    nrst = 1'b0;
    start_i = 1'b0;
    num_items_i = '0;
    mask_i = '0;
    exp_valid_i = '0;
    dut_valid_i = '0;
    exp_data_i = '0;
    dut_data_i = '0;
    last_neg_done = 1'b0;
    fill();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_err",  32'(err_cnt_o), 32'd0);
    check("rst_rdy",  32'({exp_ready_o, dut_ready_o}), 32'd0);
    nrst = 1'b1;
    tick();

    // T1: clean run with random valids
    do_start(8, 8'hFF);
    check("t1_busy", 32'(busy_o), 32'd1);
    drive(8, 8, 1'b1, 1'b1, 400, ok);
    check("t1_complete", 32'(ok), 32'd1);
    check("t1_done_before", 32'(last_neg_done), 32'd0);
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_pass", 32'(pass_o), 32'd1);
    check("t1_err", 32'(err_cnt_o), 32'd0);
    check("t1_rdy_off", 32'({exp_ready_o, dut_ready_o}), 32'd0);

    // T2: simultaneous mismatches on ch0 and ch2 at beat 5, full mask
    fill();
    exp_w[2][5] = 8'h3C; got_w[2][5] = 8'h3D;
    exp_w[0][5] = 8'h55; got_w[0][5] = 8'hD5;
    do_start(8, 8'hFF);
    drive(8, 8, 1'b1, 1'b0, 200, ok);
    check("t2_complete", 32'(ok), 32'd1);
    check("t2_done", 32'(done_o), 32'd1);
    check("t2_err", 32'(err_cnt_o), 32'd2);
    check("t2_pass", 32'(pass_o), 32'd0);
    check("t2_fe_ch", 32'(first_err_ch_o), 32'd0);
    check("t2_fe_idx", 32'(first_err_idx_o), 32'd5);
    check("t2_fe_exp", 32'(first_err_exp_o), 32'h55);
    check("t2_fe_got", 32'(first_err_got_o), 32'hD5);

    // T3: same data, bit0 masked off
    do_start(8, 8'hFE);
    check("t3_err_cleared", 32'(err_cnt_o), 32'd0);
    drive(8, 8, 1'b1, 1'b0, 200, ok);
    check("t3_complete", 32'(ok), 32'd1);
    check("t3_err", 32'(err_cnt_o), 32'd1);
    check("t3_fe_ch", 32'(first_err_ch_o), 32'd0);
    check("t3_fe_idx", 32'(first_err_idx_o), 32'd5);
    check("t3_pass", 32'(pass_o), 32'd0);

    // T4: watchdog, DUT never valid
    fill();
    do_start(8, 8'hFF);
    for (int k = 1; k <= 1024; k++) begin
      exp_valid_i = (k <= 8) ? 4'hF : 4'h0;
      tick();
      if (k == 1023) check("t4_no_timeout_1023", 32'(timeout_o), 32'd0);
    end
    exp_valid_i = '0;
    check("t4_timeout_1024", 32'(timeout_o), 32'd1);
    check("t4_done", 32'(done_o), 32'd1);
    check("t4_pass", 32'(pass_o), 32'd0);
    tick();
    check("t4_hold", 32'(timeout_o), 32'd1);

    // T5: FIFO fill with DUT stalled, then drain
    do_start(20, 8'hFF);
    drive(20, 20, 1'b0, 1'b0, 20, ok);
    check("t5_pushed_ch0", 32'(e_idx[0]), 32'd16);
    check("t5_pushed_ch3", 32'(e_idx[3]), 32'd16);
    check("t5_exp_rdy", 32'(exp_ready_o), 32'd0);
    drive(20, 20, 1'b1, 1'b1, 600, ok);
    check("t5_complete", 32'(ok), 32'd1);
    check("t5_pass", 32'(pass_o), 32'd1);
    check("t5_err", 32'(err_cnt_o), 32'd0);

    // T6: restart mid-run after 3 beats with one error
    fill();
    got_w[1][1] = 8'h00;
    do_start(8, 8'hFF);
    drive(8, 3, 1'b1, 1'b0, 200, ok);
    check("t6_partial", 32'(ok), 32'd1);
    check("t6_err1", 32'(err_cnt_o), 32'd1);
    check("t6_busy", 32'(busy_o), 32'd1);
    fill();
    do_start(8, 8'hFF);
    check("t6_err_clr", 32'(err_cnt_o), 32'd0);
    check("t6_fe_clr", 32'(first_err_idx_o), 32'd0);
    drive(8, 8, 1'b1, 1'b1, 400, ok);
    check("t6_rerun_complete", 32'(ok), 32'd1);
    check("t6_rerun_pass", 32'(pass_o), 32'd1);
    do_start(0, 8'hFF);
    check("t6_zero_run", 32'({busy_o, done_o}), 32'b10);
    tick();
    check("t6_zero_done", 32'({busy_o, done_o, pass_o}), 32'b011);

    // Asynchronous reset in the middle of a run
    do_start(8, 8'hFF);
    got_w[0][0] = 8'hAA;
    drive(8, 2, 1'b1, 1'b0, 100, ok);
    check("rst_mid_err_pre", 32'(err_cnt_o), 32'd1);
    @(negedge clk);
    nrst = 1'b0;
    #2;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_err", 32'(err_cnt_o), 32'd0);
    check("rst_mid_rdy", 32'({exp_ready_o, dut_ready_o}), 32'd0);
    nrst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
